// File: rtl/addr_gen_2d.sv
// addr_gen_2d: 2-D (row, column) address scanner with selectable inner counter, hold, abort and restart.
// Optional ADDR_GEN_2D_LIN_EN adds addr_lin, a linear element index of the current address.
module addr_gen_2d #(
    parameter int COL_W = 2,
    parameter int ROW_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [COL_W-1:0] cfg_col_last,
    input  logic [ROW_W-1:0] cfg_row_last,
    input  logic             cfg_col_major,
    output logic [COL_W-1:0] addr_col,
    output logic [ROW_W-1:0] addr_row,
    output logic             addr_vld,
    output logic             last,
    output logic             done,
    output logic             busy
`ifdef ADDR_GEN_2D_LIN_EN
    ,
    output logic [COL_W+ROW_W-1:0] addr_lin
`endif
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state;
    logic [COL_W-1:0] col, col_last, col_nxt;
    logic [ROW_W-1:0] row, row_last, row_nxt;
    logic col_major, col_end, row_end, adv;
    // col_major selects which counter wraps first; the other steps on that wrap
    always_comb begin
        col_end = col == col_last;
        row_end = row == row_last;
        col_nxt = col_major ? (row_end ? col + 1'b1 : col) : (col_end ? '0 : col + 1'b1);
        row_nxt = col_major ? (row_end ? '0 : row + 1'b1) : (col_end ? row + 1'b1 : row);
    end
    assign busy     = state == RUN;
    assign addr_vld = busy;
    assign last     = busy && col_end && row_end;
    assign adv      = busy && !hold && !start && !abort;
    assign addr_col = col;
    assign addr_row = row;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            col_last  <= '0;
            row_last  <= '0;
            col_major <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= IDLE;
                col   <= '0;
                row   <= '0;
            end else if (start) begin
                state     <= RUN;
                col       <= '0;
                row       <= '0;
                col_last  <= cfg_col_last;
                row_last  <= cfg_row_last;
                col_major <= cfg_col_major;
            end else if (adv) begin
                if (last) begin
                    state <= IDLE;
                    col   <= '0;
                    row   <= '0;
                    done  <= 1'b1;
                end else begin
                    col <= col_nxt;
                    row <= row_nxt;
                end
            end
        end
    end
`ifdef ADDR_GEN_2D_LIN_EN
    always_ff @(posedge clk) begin
        if (rst || abort || start || (adv && last))
            addr_lin <= '0;
        else if (adv)
            addr_lin <= addr_lin + 1'b1;
    end
`endif
endmodule

// File: tb/tb_addr_gen_2d.sv
// tb_addr_gen_2d: vector table, corner sequences and random stimulus against a scan-list reference model.
// Builds with or without ADDR_GEN_2D_LIN_EN.
module tb_addr_gen_2d;
    logic clk = 1'b0;
    logic rst, start, abort, hold, cfg_col_major;
    logic [1:0] cfg_col_last, cfg_row_last, addr_col, addr_row;
    logic addr_vld, last, done, busy;
`ifdef ADDR_GEN_2D_LIN_EN
    logic [3:0] addr_lin;
`endif
    always #5 clk = ~clk;

    addr_gen_2d #(.COL_W(2), .ROW_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
        .cfg_col_last(cfg_col_last), .cfg_row_last(cfg_row_last), .cfg_col_major(cfg_col_major),
        .addr_col(addr_col), .addr_row(addr_row), .addr_vld(addr_vld),
        .last(last), .done(done), .busy(busy)
`ifdef ADDR_GEN_2D_LIN_EN
        , .addr_lin(addr_lin)
`endif
    );

    int checks = 0, failures = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // reference: the whole scan is a precomputed list of (row, col); m_p indexes it
    bit m_run, m_done;
    int m_p;
    int qr[$], qc[$];
    task automatic model_edge(input bit rs, st, ab, hd, input int cl, rl, input bit cm);
        if (rs) begin
            m_run = 0; m_p = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (ab) m_run = 0;
        else if (st) begin
            qr.delete(); qc.delete();
            if (!cm) begin
                for (int r = 0; r <= rl; r++) for (int c = 0; c <= cl; c++) begin qr.push_back(r); qc.push_back(c); end
            end else begin
                for (int c = 0; c <= cl; c++) for (int r = 0; r <= rl; r++) begin qr.push_back(r); qc.push_back(c); end
            end
            m_run = 1; m_p = 0;
        end else if (m_run && !hd) begin
            if (m_p == qr.size() - 1) begin m_run = 0; m_done = 1; end
            else m_p++;
        end
    endtask

    task automatic step(input bit rs, st, ab, hd, input int cl, rl, input bit cm);
        logic [1:0] er, ec;
        logic ml;
        rst = rs; start = st; abort = ab; hold = hd;
        cfg_col_last = 2'(cl); cfg_row_last = 2'(rl); cfg_col_major = cm;
        model_edge(rs, st, ab, hd, cl, rl, cm);
        @(posedge clk);
        #1;
        er = m_run ? 2'(qr[m_p]) : 2'd0;
        ec = m_run ? 2'(qc[m_p]) : 2'd0;
        ml = m_run && (m_p == qr.size() - 1);
        chk("model", {addr_vld, busy, last, done, addr_row, addr_col}, {m_run, m_run, ml, m_done, er, ec});
`ifdef ADDR_GEN_2D_LIN_EN
        chk("model_lin", addr_lin, m_run ? m_p : 0);
`else
        chk("model_nolin_busy", busy, m_run);
`endif
    endtask

    typedef struct {
        bit st, ab, hd;
        int cl, rl;
        bit cm, vld;
        int col, row;
        bit lst, dn;
        int lin;
    } vec_t;
    vec_t tbl[20];

    initial begin
        int vc, at12, hl, nseen;
        bit seen[16];
        bit got_done, h;
        tbl[0]  = '{1,0,0,1,1,0, 1,0,0,0,0,0};
        tbl[1]  = '{0,0,0,1,1,0, 1,1,0,0,0,1};
        tbl[2]  = '{0,0,0,1,1,0, 1,0,1,0,0,2};
        tbl[3]  = '{0,0,0,1,1,0, 1,1,1,1,0,3};
        tbl[4]  = '{0,0,0,1,1,0, 0,0,0,0,1,0};
        tbl[5]  = '{0,0,1,1,1,0, 0,0,0,0,0,0};
        tbl[6]  = '{1,0,0,1,1,1, 1,0,0,0,0,0};
        tbl[7]  = '{0,0,0,3,3,0, 1,0,1,0,0,1};
        tbl[8]  = '{0,0,0,0,0,0, 1,1,0,0,0,2};
        tbl[9]  = '{0,0,0,1,1,1, 1,1,1,1,0,3};
        tbl[10] = '{0,0,0,1,1,1, 0,0,0,0,1,0};
        tbl[11] = '{1,0,0,0,0,0, 1,0,0,1,0,0};
        tbl[12] = '{0,0,0,0,0,0, 0,0,0,0,1,0};
        tbl[13] = '{0,0,0,0,0,0, 0,0,0,0,0,0};
        tbl[14] = '{1,0,0,1,1,0, 1,0,0,0,0,0};
        tbl[15] = '{1,1,0,1,1,0, 0,0,0,0,0,0};
        tbl[16] = '{0,0,0,1,1,0, 0,0,0,0,0,0};
        tbl[17] = '{1,0,0,0,0,0, 1,0,0,1,0,0};
        tbl[18] = '{1,0,0,0,0,0, 1,0,0,1,0,0};
        tbl[19] = '{0,0,0,0,0,0, 0,0,0,0,1,0};

        step(1, 1, 0, 1, 3, 3, 1);
        chk("reset", {addr_vld, busy, last, done, addr_row, addr_col}, 8'h00);

        for (int i = 0; i < 20; i++) begin
            step(0, tbl[i].st, tbl[i].ab, tbl[i].hd, tbl[i].cl, tbl[i].rl, tbl[i].cm);
            chk($sformatf("vec%0d", i), {addr_vld, addr_col, addr_row, last, done},
                {tbl[i].vld, 2'(tbl[i].col), 2'(tbl[i].row), tbl[i].lst, tbl[i].dn});
`ifdef ADDR_GEN_2D_LIN_EN
            chk($sformatf("vec%0d_lin", i), addr_lin, tbl[i].lin);
`endif
        end

        // 4x3 scan with a two-cycle hold at row 1, col 2
        step(0, 1, 0, 0, 3, 2, 0);
        vc = 0; at12 = 0; hl = 0; got_done = 0;
        foreach (seen[k]) seen[k] = 0;
        for (int k = 0; k < 40 && !got_done; k++) begin
            if (addr_vld) begin
                vc++;
                seen[addr_row * 4 + addr_col] = 1;
                if (addr_row == 1 && addr_col == 2) at12++;
            end
            h = addr_vld && addr_row == 1 && addr_col == 2 && hl < 2;
            if (h) hl++;
            step(0, 0, 0, h, 0, 0, 0);
            if (done) got_done = 1;
        end
        nseen = 0;
        foreach (seen[k]) nseen += int'(seen[k]);
        chk("hold_vld_cycles", vc, 14);
        chk("hold_at_1_2", at12, 3);
        chk("hold_distinct", nseen, 12);
        chk("hold_done", got_done, 1);

        // restart at scan address 2
        step(0, 1, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        chk("addr2", {addr_row, addr_col}, 4'b0100);
        step(0, 1, 0, 0, 1, 1, 0);
        chk("restart", {addr_vld, addr_row, addr_col, done}, 6'b100000);
        step(0, 0, 0, 0, 1, 1, 0);
        chk("restart_next", {addr_row, addr_col}, 4'b0001);

        // reset at third address of a 2x2 scan
        step(0, 1, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 1, 1, 0);
        chk("rst_mid", {addr_vld, busy, last, done, addr_row, addr_col}, 8'h00);
        step(0, 0, 0, 0, 1, 1, 0);
        chk("rst_no_done", {addr_vld, done}, 2'b00);

        for (int k = 0; k < 400; k++)
            step($urandom_range(63) == 0, $urandom_range(7) == 0, $urandom_range(31) == 0,
                 $urandom_range(3) == 0, $urandom_range(3), $urandom_range(3), $urandom_range(1) == 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/addr_gen_2d.md
ADDR_GEN_2D -- requirements
Module: addr_gen_2d

Interface
REQ-001 Parameter COL_W, default 2, width of the column (S) address.
REQ-002 Parameter ROW_W, default 2, width of the row (H) address.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  begin or restart a scan using the current cfg_* values.
REQ-006 abort  input  1  terminate the scan and return to IDLE.
REQ-007 hold  input  1  stall; the address is frozen while high.
REQ-008 cfg_col_last  input  COL_W  terminal column index (column count minus 1).
REQ-009 cfg_row_last  input  ROW_W  terminal row index (row count minus 1).
REQ-010 cfg_col_major  input  1  0: column is the inner counter; 1: row is the inner counter.
REQ-011 addr_col  output  COL_W  current column address.
REQ-012 addr_row  output  ROW_W  current row address.
REQ-013 addr_vld  output  1  addr_col/addr_row are valid this cycle.
REQ-014 last  output  1  current address is the final one of the scan.
REQ-015 done  output  1  one-cycle pulse after the final address is consumed.
REQ-016 busy  output  1  high in RUN.

Function
REQ-017 The FSM SHALL have states IDLE and RUN; addr_vld = busy = (state==RUN).
REQ-018 cfg_col_last, cfg_row_last and cfg_col_major SHALL be latched on the start cycle and held for the whole scan; cfg changes mid-scan have no effect.
REQ-019 start in IDLE or RUN (abort low) SHALL load col=0, row=0, state=RUN on the next edge; a start in RUN restarts the scan and emits no done.
REQ-020 In RUN with hold low, the inner counter SHALL advance by 1 each cycle; at its latched terminal index it wraps to 0 and the outer counter advances by 1.
REQ-021 In RUN with hold high, all counters, last and state SHALL hold their values.
REQ-022 last = RUN and inner==inner_last and outer==outer_last (combinational from registered state).
REQ-023 An advance while last is high SHALL set state to IDLE, reset col and row to 0, and pulse done for exactly the following cycle.
REQ-024 abort SHALL force IDLE, col=0, row=0 on the next edge with no done; abort has priority over start and hold.
REQ-025 start coinciding with the final advance SHALL restart the scan (RUN, 0/0) with no done pulse.
REQ-026 A 1x1 configuration (both last fields 0) SHALL produce one valid cycle with last=1, then done.
REQ-027 Counters SHALL never exceed their latched terminal index; there is no wrap beyond 2^W.
REQ-028 In IDLE, addr_col=0, addr_row=0, last=0, and hold is ignored.

Reset
REQ-029 rst SHALL have priority over all inputs; on the next edge state=IDLE, addr_col=0, addr_row=0, addr_vld=0, last=0, done=0, busy=0, latched cfg=0.
REQ-030 rst asserted mid-scan SHALL abandon the scan with no done pulse.

Configuration
REQ-031 Macro ADDR_GEN_2D_LIN_EN: when defined, the block SHALL add output addr_lin [COL_W+ROW_W-1:0], a sequential element index that is 0 at scan start, increments with every advance, holds under hold, and is 0 in IDLE and after reset.
REQ-032 When ADDR_GEN_2D_LIN_EN is undefined, the addr_lin port and its counter SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-033 cfg_col_last=1, cfg_row_last=1, cfg_col_major=0, one start pulse -> (row,col) = (0,0),(0,1),(1,0),(1,1) on four consecutive cycles, last on the 4th, done on the 5th, then idle.
REQ-034 Same configuration with cfg_col_major=1 -> (0,0),(1,0),(0,1),(1,1); with ADDR_GEN_2D_LIN_EN defined, addr_lin = 0,1,2,3.
REQ-035 cfg_col_last=3, cfg_row_last=2, hold high for 2 cycles at (1,2) -> (1,2) is held 3 cycles, 12 distinct addresses are produced, done follows the last.
REQ-036 start again at scan address 2 -> next cycle (0,0), no done; abort together with start -> IDLE, no done.
REQ-037 1x1 configuration -> one addr_vld cycle with last=1, then done; rst at 3rd address of a 2x2 scan -> all outputs 0 next cycle, no done.
